// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exponent thresholds, int32 limits and the
// float-to-int operand class code.
package fpu_pkg;

  localparam logic [7:0]  EXP_BIAS      = 8'd127;
  localparam logic [7:0]  FTOI_EXP_MIN  = 8'd126;
  localparam logic [7:0]  FTOI_EXP_SAT  = 8'd158;
  // Exponent at which {1,m,8'b0} needs no right shift (|x| in [2^30, 2^31)).
  localparam logic [7:0]  FTOI_EXP_TOP  = EXP_BIAS + 8'd30;
  localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_SAT    = 2'd1,
    CLS_NAN    = 2'd2,
    CLS_NORMAL = 2'd3
  } ftoi_cls_t;

  // Classify an operand from its exponent and mantissa fields.
  function automatic ftoi_cls_t ftoi_classify(input logic [7:0] e, input logic [22:0] m);
    if (e == 8'hFF && m != 23'd0) return CLS_NAN;
    if (e < FTOI_EXP_MIN)         return CLS_ZERO;
    if (e >= FTOI_EXP_SAT)        return CLS_SAT;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/ftoi_round.sv
// Combinational second-stage datapath of the float-to-int converter:
// align the significand, round half away from zero, negate and saturate.
module ftoi_round
  import fpu_pkg::*;
(
  input  logic        sgn,
  input  logic [7:0]  ex,
  input  logic [23:0] man,
  input  ftoi_cls_t   cls,
  output logic [31:0] res
);

  // Round floor(2|x|) to |x| with ties going away from zero.
  function automatic logic [32:0] rnd_half_away(input logic [31:0] q);
    return ({1'b0, q} + 33'd1) >> 1;
  endfunction

  // Apply the sign and clamp the magnitude into the int32 range.
  function automatic logic [31:0] sat_int32(input logic s, input logic [32:0] mag);
    logic signed [32:0] sval;
    if (!s && mag >= 33'h0_8000_0000) return INT32_MAX;
    if (s && mag > 33'h0_8000_0000)   return INT32_MIN;
    sval = s ? -$signed(mag) : $signed(mag);
    return sval[31:0];
  endfunction

  logic [4:0]  shamt;
  logic [31:0] q;
  logic [32:0] mag;

  // Shift, round and saturate according to the operand class.
  always_comb begin
    shamt = 5'(FTOI_EXP_TOP - ex);
    q     = {man, 8'b0} >> shamt;
    mag   = rnd_half_away(q);
    res   = 32'd0;
    case (cls)
      CLS_ZERO:   res = 32'd0;
      CLS_NAN:    res = INT32_MAX;
      CLS_SAT:    res = sgn ? INT32_MIN : INT32_MAX;
      CLS_NORMAL: res = sat_int32(sgn, mag);
      default:    res = 32'd0;
    endcase
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined IEEE-754 single to signed int32 converter with
// valid/ready handshakes on both sides.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rs1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      rd,
  output logic [TAG_W-1:0] out_tag
);

  logic             vld_p1, vld_p2;
  logic             s_p1;
  logic [7:0]       e_p1;
  logic [23:0]      man_p1;
  ftoi_cls_t        cls_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [31:0]      rd_p2;
  logic [TAG_W-1:0] tag_p2;
  logic [31:0]      res_p1;
  logic             s1_advance;

  assign s1_advance = !vld_p2 || out_ready;
  assign in_ready   = !vld_p1 || s1_advance;
  assign out_valid  = vld_p2;
  assign rd         = rd_p2;
  assign out_tag    = tag_p2;

  // ---- stage 1: unpack and classify ----
  // Stage-1 occupancy follows the input handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // Stage-1 operand fields; loaded only on an accepted input.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s_p1   <= rs1[31];
      e_p1   <= rs1[30:23];
      man_p1 <= {1'b1, rs1[22:0]};
      cls_p1 <= ftoi_classify(rs1[30:23], rs1[22:0]);
      tag_p1 <= in_tag;
    end
  end

  // ---- stage 2: shift, round, negate, saturate ----
  ftoi_round u_round (
    .sgn (s_p1),
    .ex  (e_p1),
    .man (man_p1),
    .cls (cls_p1),
    .res (res_p1)
  );

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2 <= 1'b0;
      rd_p2  <= 32'd0;
      tag_p2 <= '0;
    end else if (s1_advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        rd_p2  <= res_p1;
        tag_p2 <= tag_p1;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: vector table, backpressure, streaming and reset.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd;
  logic [4:0]  out_tag;

  ftoi_pipe #(.TAG_W(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic [4:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc = 0;
  int   npop = 0;
  int   last_pop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: floor(2|x|) = mant24 * 2^(e-149), then (x2+1)/2 and clamp.
  function automatic logic [31:0] ref_cvt(input logic [31:0] f);
    logic       s;
    int         e;
    longint     mant, x2, a, v;
    s    = f[31];
    e    = int'(f[30:23]);
    mant = longint'({1'b1, f[22:0]});
    if (e == 255 && f[22:0] != 0) return 32'h7FFF_FFFF;
    if (e < 126) return 32'h0;
    if (e >= 158) return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e >= 149) x2 = mant << (e - 149);
    else          x2 = mant >> (149 - e);
    a = (x2 + 1) >>> 1;
    v = s ? -a : a;
    if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  // Scoreboard: every transferred result must match the oldest pending one.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", rd, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd", rd, e.rd);
        check("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
        npop++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [31:0] f, input logic [4:0] t, input logic [31:0] r);
    bit ok = 0;
    rs1 = f;
    in_tag = t;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{rd: r, tag: t});
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: f[30:23] = 8'($urandom_range(120, 160));
      default: f[30:23] = 8'($urandom_range(126, 157));
    endcase
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  initial begin
    logic [31:0] f;
    int start_cyc, npop0;

    tbl[0]  = '{32'h3FC0_0000, 32'h0000_0002};
    tbl[1]  = '{32'hC020_0000, 32'hFFFF_FFFD};
    tbl[2]  = '{32'h3ECC_CCCD, 32'h0000_0000};
    tbl[3]  = '{32'h4F00_0000, 32'h7FFF_FFFF};
    tbl[4]  = '{32'hCF00_0000, 32'h8000_0000};
    tbl[5]  = '{32'h7F80_0000, 32'h7FFF_FFFF};
    tbl[6]  = '{32'hFF80_0000, 32'h8000_0000};
    tbl[7]  = '{32'h7FC0_0000, 32'h7FFF_FFFF};
    tbl[8]  = '{32'h8000_0000, 32'h0000_0000};
    tbl[9]  = '{32'h4640_E400, 32'h0000_3039};
    tbl[10] = '{32'h4EFF_FFFF, 32'h7FFF_FF80};
    tbl[11] = '{32'hCEFF_FFFF, 32'h8000_0080};
    tbl[12] = '{32'h3F00_0000, 32'h0000_0001};
    tbl[13] = '{32'hBF00_0000, 32'hFFFF_FFFF};
    tbl[14] = '{32'hBE99_999A, 32'h0000_0000};
    tbl[15] = '{32'h0000_0001, 32'h0000_0000};

    rstn = 1'b0;
    in_valid = 1'b0;
    rs1 = 32'd0;
    in_tag = 5'd0;
    out_ready = 1'b1;

    // Reset values
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Vector table, one at a time, checking two-cycle latency
    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].f, 5'(i), tbl[i].r);
      check("lat_early", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("lat_two", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Backpressure: tags 1,2,3 with the consumer stalled
    out_ready = 1'b0;
    issue(32'h3FC0_0000, 5'd1, 32'h0000_0002);
    issue(32'hC020_0000, 5'd2, 32'hFFFF_FFFD);
    rs1 = 32'h4640_E400;
    in_tag = 5'd3;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_rd", rd, 32'h0000_0002);
      check("stall_out_tag", {27'd0, out_tag}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(32'h4640_E400, 5'd3, 32'h0000_3039);
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 32'd0);

    // Streaming: 100 back-to-back random operands
    start_cyc = cyc;
    npop0 = npop;
    for (int k = 0; k < 100; k++) begin
      f = rnd_op();
      issue(f, 5'(k), ref_cvt(f));
    end
    for (int k = 0; k < 10 && (npop - npop0) < 100; k++) @(posedge clk);
    #1;
    check("stream_count", npop - npop0, 32'd100);
    check("stream_cycles", last_pop_cyc - start_cyc, 32'd101);

    // Asynchronous reset with two operations in flight
    out_ready = 1'b0;
    issue(32'h3FC0_0000, 5'd7, 32'h0000_0002);
    issue(32'hC020_0000, 5'd8, 32'hFFFF_FFFD);
    #3 rstn = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_rd", rd, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue(32'h4EFF_FFFF, 5'd9, 32'h7FFF_FF80);
    check("post_rst_lat_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_lat_two", {31'd0, out_valid}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("final_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
# ftoi_pipe

Two-stage pipelined float-to-integer converter (`fcvt.w.s`-class op) in the FPU. It converts an IEEE-754 single into a signed 32-bit integer, rounding to nearest with ties away from zero. It is the inverse-direction neighbour of the int-to-float path: it reads FPU register operands and writes the integer register file. Valid/ready handshakes on both sides let the core issue one conversion per cycle and stall on writeback backpressure.

## Interface
Parameters:
- `TAG_W`, default 5: width of the destination-register tag carried alongside each operation.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: an operand is presented on `rs1`/`in_tag`.
- `in_ready` output 1: the block accepts the operand this cycle.
- `rs1` input 32: IEEE-754 single operand.
- `in_tag` input `TAG_W`: destination tag, passed through unchanged.
- `out_valid` output 1: a result is presented on `rd`/`out_tag`.
- `out_ready` input 1: the consumer accepts the result this cycle.
- `rd` output 32: signed two's-complement result.
- `out_tag` output `TAG_W`: tag of the result.

## Operation
- Unpack `rs1` into sign `s`, exponent `e[7:0]` and mantissa `m[22:0]`.
- `e < 126` (zero, denormals, |x| < 0.5): result 0. Sign is ignored, so -0.3 gives 0x00000000.
- `e == 255 && m != 0` (NaN): result 0x7FFFFFFF.
- `e >= 158` (|x| >= 2^31, including ±inf): result 0x7FFFFFFF if `s==0`, 0x80000000 if `s==1`.
- `126 <= e <= 157`:
  - q[31:0] = floor(|x|·2) = {1,m,8'b0} >> (157 - e); shift amount is 0..31.
  - a[32:0] = (q + 1) >> 1, giving round-half-away-from-zero.
  - If `s==0` and a ≥ 2^31: result 0x7FFFFFFF.
  - If `s==1` and a > 2^31: result 0x80000000. a == 2^31 with `s==1` gives 0x80000000 exactly.
  - Otherwise the result is `s ? -a : a`, truncated to 32 bits.
- Stage 1 (S1): register `s`, `e`, `{1,m}`, a 2-bit class code (ZERO/SAT/NAN/NORMAL) and the tag.
- Stage 2 (S2): shift, round, negate and saturate; register `rd` and `out_tag`.

## Timing
- Latency: exactly 2 cycles from an accepted input to `out_valid` when there is no stall. Throughput is 1 per cycle.
- Input handshake:
  - The input is accepted when `in_valid && in_ready`.
  - `in_ready = !s1_valid || s1_advance`.
  - `s1_advance = !s2_valid || out_ready`.
- Output handshake:
  - The result is transferred when `out_valid && out_ready`.
  - `rd`/`out_tag` hold stable while `out_valid && !out_ready`.
- Full pipe with `out_ready` low: both stages hold and `in_ready` is 0. No data is dropped or duplicated, and results leave in issue order.
- Simultaneous pop and push on a full pipe: both happen in the same cycle with no bubble.
- `in_ready` may depend combinationally on `out_ready`. `out_valid` and `rd` come from registers only.
- Reset values: `s1_valid`=0, `s2_valid`=0, `out_valid`=0, `rd`=0, `out_tag`=0. `in_ready` is 1 during and after reset.
- Reset asserted mid-operation discards all in-flight operations immediately, with no output.
- Data registers need no reset; only the valid bits and the `rd`/`out_tag` output registers are reset.

## Structure
- Shared package `fpu_pkg`:
  - `EXP_BIAS`=127, `FTOI_EXP_MIN`=126, `FTOI_EXP_SAT`=158.
  - `INT32_MAX`=32'h7FFFFFFF, `INT32_MIN`=32'h80000000.
  - Class-code enum `ftoi_cls_t`.
- One sub-module, `ftoi_round`: combinational S2 datapath (shift, round, negate, saturate).
- The pipeline registers and handshake logic live in `ftoi_pipe`.

## Test plan
- Rounding: 0x3FC00000 (1.5) → 0x00000002; 0xC0200000 (-2.5) → 0xFFFFFFFD; 0x3ECCCCCD (0.4) → 0x00000000. Each appears 2 cycles after acceptance with `out_ready`=1.
- Saturation and special values:
  - 0x4F000000 (2^31) → 0x7FFFFFFF.
  - 0xCF000000 (-2^31) → 0x80000000.
  - 0x7F800000 (+inf) → 0x7FFFFFFF; 0xFF800000 (-inf) → 0x80000000.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF.
  - 0x80000000 (-0) → 0.
- Round trip: 0x4640E400 (the int-to-float result for 12345) → 0x00003039. 0x4EFFFFFF → 0x7FFFFF80.
- Backpressure: issue tags 1,2,3 on consecutive cycles with `out_ready`=0.
  - `in_ready` falls after two are held; tag 3 waits.
  - Raising `out_ready` drains tags 1,2,3 in order, one per cycle, each with the correct `rd`.
  - `rd` stays stable while stalled.
- Streaming: 100 back-to-back random operands with `out_ready`=1 give 100 results in 101 cycles, all matching the reference model.
- Reset: drop `rstn` asynchronously with 2 operations in flight.
  - `out_valid` goes to 0 immediately and `rd`=0.
  - After release, no stale results appear and the next input completes in 2 cycles.
